// File: rtl/emul_demux_axil_arbiter_pkg.sv
// Shared types and constants for the emul_demux AXI4-Lite arbiter.
// Provides the FSM state enum, AXI response codes and default PROT.
package emul_demux_axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;
    localparam logic [1:0] RESP_DECERR      = 2'b11;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/emul_demux_axil_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the register block (slave).
// Channels: AW, W, B, AR, R; master modport drives VALIDs/payload, slave drives READYs/responses.
interface emul_demux_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/emul_demux_axil_arbiter_rr.sv
// Combinational round-robin picker: searches last_grant+1, +2, ... modulo NUM_REQ.
// Ports: req (request vector), last_grant in; grant (one-hot), grant_idx, any out.
module emul_demux_rr_arbiter
    import emul_demux_axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_grant) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/emul_demux_axil_arbiter.sv
// Shares one AXI4-Lite slave among NUM_REQ requesters, one transaction at a time, round-robin.
// Ports: ACLK/ARESETN, per-requester req_*/rsp_valid, shared rsp_rdata/rsp_resp, busy, grant_idx, m_axi master bus.
module emul_demux_axil_arbiter
    import emul_demux_axil_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    emul_demux_axil_arbiter_if.master     m_axi
);

    localparam int IW = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic [IW-1:0]           grant_idx_q, grant_idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [IW-1:0]           arb_idx;
    logic                    arb_any;
    logic                    grant_fire;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic [3:0]              win_wstrb;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    emul_demux_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    assign grant_fire = (state_q == IDLE) && arb_any;
    assign aw_hs      = m_axi.awvalid && m_axi.awready;
    assign w_hs       = m_axi.wvalid  && m_axi.wready;
    assign b_hs       = m_axi.bvalid  && m_axi.bready;
    assign ar_hs      = m_axi.arvalid && m_axi.arready;
    assign r_hs       = m_axi.rvalid  && m_axi.rready;

    // Winner payload mux; constant slice bounds after unrolling.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                win_wstrb = req_wstrb[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_idx_q  <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_any) state_d = win_we ? WR : RD_ADDR;
            // AW and W may complete in either order or together.
            WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                         state_d = WR_RESP;
            WR_RESP: if (b_hs)  state_d = IDLE;
            RD_ADDR: if (ar_hs) state_d = RD_RESP;
            RD_RESP: if (r_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        grant_idx_d  = grant_idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;
        if (grant_fire) begin
            last_grant_d = arb_idx;
            grant_idx_d  = arb_idx;
            addr_d       = win_addr;
            wdata_d      = win_wdata;
            wstrb_d      = win_wstrb;
            aw_done_d    = 1'b0;
            w_done_d     = 1'b0;
        end
        if (state_q == WR) begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q  || w_hs;
        end
        if (b_hs) begin
            rsp_valid_d[grant_idx_q] = 1'b1;
            rsp_rdata_d              = '0;
            rsp_resp_d               = m_axi.bresp;
        end
        if (r_hs) begin
            rsp_valid_d[grant_idx_q] = 1'b1;
            rsp_rdata_d              = m_axi.rdata;
            rsp_resp_d               = m_axi.rresp;
        end
    end

    always_comb begin
        req_ready       = (state_q == IDLE) ? arb_grant : '0;
        busy            = (state_q != IDLE);
        m_axi.awaddr    = addr_q;
        m_axi.awprot    = AXI_PROT_DEFAULT;
        m_axi.awvalid   = (state_q == WR) && !aw_done_q;
        m_axi.wdata     = wdata_q;
        m_axi.wstrb     = wstrb_q;
        m_axi.wvalid    = (state_q == WR) && !w_done_q;
        m_axi.bready    = (state_q == WR_RESP);
        m_axi.araddr    = addr_q;
        m_axi.arprot    = AXI_PROT_DEFAULT;
        m_axi.arvalid   = (state_q == RD_ADDR);
        m_axi.rready    = (state_q == RD_RESP);
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_emul_demux_axil_arbiter.sv
// Directed bench for emul_demux_axil_arbiter with a small 4-register AXI4-Lite slave model.
// Each scenario task drives requests and compares against hand-computed values.
module tb_emul_demux_axil_arbiter;
    import emul_demux_axil_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [0:0]  grant_idx;

    logic [3:0]  r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wstrb [2];

    assign req_addr  = {r_addr[1], r_addr[0]};
    assign req_wdata = {r_wdata[1], r_wdata[0]};
    assign req_wstrb = {r_wstrb[1], r_wstrb[0]};

    emul_demux_axil_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

    emul_demux_axil_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32)
    ) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .busy      (busy),
        .grant_idx (grant_idx),
        .m_axi     (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // Slave model: readies/responses change on the falling edge only.
    int          aw_stall = 0;
    bit          err8     = 1'b0;
    bit          r_hold   = 1'b0;
    int          b_count  = 0;
    logic [31:0] mem [4];
    bit          p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb;
    logic [31:0] p_wdata;
    bit          aw_have, w_have, ar_have;
    logic [3:0]  s_awaddr, s_araddr, s_wstrb;
    logic [31:0] s_wdata, s_mask;

    always @(negedge clk) begin
        if (!rst_n) begin
            axi.awready = 1'b0; axi.wready = 1'b0;
            axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
            axi.arready = 1'b0; axi.rvalid = 1'b0;
            axi.rdata   = '0;   axi.rresp  = 2'b00;
            aw_have = 1'b0; w_have = 1'b0; ar_have = 1'b0;
        end else begin
            if (p_awv && axi.awready) begin aw_have = 1'b1; s_awaddr = p_awaddr; end
            if (p_wv && axi.wready) begin w_have = 1'b1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
            if (p_arv && axi.arready) begin ar_have = 1'b1; s_araddr = p_araddr; end
            if (p_bready && axi.bvalid) begin axi.bvalid = 1'b0; b_count++; end
            if (p_rready && axi.rvalid) axi.rvalid = 1'b0;
            if (aw_have && w_have && !axi.bvalid) begin
                s_mask = {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}};
                mem[s_awaddr[3:2]] = (mem[s_awaddr[3:2]] & ~s_mask) | (s_wdata & s_mask);
                axi.bvalid = 1'b1;
                axi.bresp  = (err8 && s_awaddr == 4'h8) ? RESP_SLVERR : RESP_OKAY;
                aw_have = 1'b0; w_have = 1'b0;
            end
            if (ar_have && !axi.rvalid && !r_hold) begin
                axi.rvalid = 1'b1;
                axi.rdata  = mem[s_araddr[3:2]];
                axi.rresp  = RESP_OKAY;
                ar_have = 1'b0;
            end
            if (axi.awvalid && !aw_have) begin
                if (aw_stall > 0) begin axi.awready = 1'b0; aw_stall--; end
                else axi.awready = 1'b1;
            end else begin
                axi.awready = 1'b0;
            end
            axi.wready  = axi.wvalid && !w_have;
            axi.arready = axi.arvalid && !ar_have;
        end
        p_awv = axi.awvalid; p_awaddr = axi.awaddr;
        p_wv  = axi.wvalid;  p_wdata  = axi.wdata; p_wstrb = axi.wstrb;
        p_arv = axi.arvalid; p_araddr = axi.araddr;
        p_bready = axi.bready; p_rready = axi.rready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit i, input bit we, input logic [3:0] a,
                         input logic [31:0] d, output int gcyc, output bit gto);
        req_we[i] = we; r_addr[i] = a; r_wdata[i] = d; r_wstrb[i] = 4'hF;
        req_valid[i] = 1'b1;
        gto = 1'b1; gcyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin gcyc = cyc; gto = 1'b0; break; end
        end
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input bit i, output int rcyc, output bit rto);
        rto = 1'b1; rcyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin rcyc = cyc; rto = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
        checks++; if (grant_idx !== 1'b0) $display("FAIL reset_grant_idx got=%0d exp=0", grant_idx); else passed++;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); else passed++;
        checks++; if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00)
            $display("FAIL reset_rsp got=%h/%b exp=0/00", rsp_rdata, rsp_resp); else passed++;
        checks++; if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0)
            $display("FAIL reset_axi_ctl got=%b exp=00000",
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); else passed++;
        checks++; if (axi.awaddr !== 4'h0 || axi.wdata !== 32'h0 || axi.wstrb !== 4'h0)
            $display("FAIL reset_payload got=%h/%h/%h exp=0/0/0", axi.awaddr, axi.wdata, axi.wstrb); else passed++;
    endtask

    task automatic test_arbitration();
        int  ng, nr;
        bit  own, exp_g;
        ng = 0; nr = 0; own = 1'b0; exp_g = 1'b0;
        req_we = 2'b11;
        r_addr[0] = 4'h0; r_wdata[0] = 32'h11; r_wstrb[0] = 4'hF;
        r_addr[1] = 4'h4; r_wdata[1] = 32'h22; r_wstrb[1] = 4'hF;
        req_valid = 2'b11;
        for (int k = 0; k < 100 && nr < 6; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                checks++; if (rsp_valid !== (own ? 2'b10 : 2'b01))
                    $display("FAIL arb_rsp_owner got=%b exp=%b", rsp_valid, own ? 2'b10 : 2'b01); else passed++;
                checks++; if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00)
                    $display("FAIL arb_rsp_data got=%h/%b exp=0/00", rsp_rdata, rsp_resp); else passed++;
                nr++;
            end
            if (req_ready != 2'b00) begin
                checks++; if (req_ready !== (exp_g ? 2'b10 : 2'b01))
                    $display("FAIL arb_grant%0d got=%b exp=%b", ng, req_ready, exp_g ? 2'b10 : 2'b01); else passed++;
                own = req_ready[1];
                exp_g = ~exp_g;
                ng++;
            end
            step();
            if (ng >= 6) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        checks++; if (ng != 6 || nr != 6)
            $display("FAIL arb_count got=%0d/%0d exp=6/6", ng, nr); else passed++;
    endtask

    task automatic test_write_read();
        int g, r;
        bit gto, rto;
        for (int j = 0; j < 8; j++) begin
            issue(1'b0, j < 4, 4'((j % 4) * 4), 32'(j % 4 + 1), g, gto);
            wait_rsp(1'b0, r, rto);
            checks++; if (gto || rto || r - g != 3)
                $display("FAIL wr_rd_latency%0d got=%0d exp=3", j, r - g); else passed++;
            checks++; if (rsp_resp !== RESP_OKAY)
                $display("FAIL wr_rd_resp%0d got=%b exp=00", j, rsp_resp); else passed++;
            checks++; if (rsp_rdata !== (j < 4 ? 32'h0 : 32'(j % 4 + 1)))
                $display("FAIL wr_rd_rdata%0d got=%h exp=%h", j, rsp_rdata,
                         j < 4 ? 32'h0 : 32'(j % 4 + 1)); else passed++;
            step();
        end
    endtask

    task automatic test_slverr();
        int g, r;
        bit gto, rto;
        err8 = 1'b1;
        issue(1'b0, 1'b1, 4'h8, 32'h33, g, gto);
        wait_rsp(1'b0, r, rto);
        checks++; if (gto || rto || r - g != 3)
            $display("FAIL err_latency got=%0d exp=3", r - g); else passed++;
        checks++; if (rsp_resp !== RESP_SLVERR)
            $display("FAIL err_resp got=%b exp=10", rsp_resp); else passed++;
        checks++; if (rsp_rdata !== 32'h0)
            $display("FAIL err_rdata got=%h exp=0", rsp_rdata); else passed++;
        checks++; if (busy !== 1'b0)
            $display("FAIL err_idle got=%b exp=0", busy); else passed++;
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || rsp_resp !== RESP_SLVERR)
            $display("FAIL err_hold got=%b/%b exp=00/10", rsp_valid, rsp_resp); else passed++;
        err8 = 1'b0;
        step();
    endtask

    task automatic test_aw_stall();
        int g, rc, aw_n, w_n, rs, b0, bad;
        bit gto;
        aw_n = 0; w_n = 0; rs = 0; rc = 0; bad = 0;
        b0 = b_count;
        aw_stall = 3;
        issue(1'b0, 1'b1, 4'hC, 32'h55, g, gto);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (axi.awvalid) begin
                aw_n++;
                if (axi.awaddr !== 4'hC) bad++;
            end
            if (axi.wvalid) begin
                w_n++;
                if (axi.wdata !== 32'h55 || axi.wstrb !== 4'hF) bad++;
            end
            if (rsp_valid[0]) begin rs++; rc = cyc; end
        end
        checks++; if (gto || aw_n != 4) $display("FAIL stall_awvalid got=%0d exp=4", aw_n); else passed++;
        checks++; if (w_n != 1) $display("FAIL stall_wvalid got=%0d exp=1", w_n); else passed++;
        checks++; if (rs != 1) $display("FAIL stall_rsp_count got=%0d exp=1", rs); else passed++;
        checks++; if (b_count - b0 != 1) $display("FAIL stall_b_count got=%0d exp=1", b_count - b0); else passed++;
        checks++; if (rc - g != 6) $display("FAIL stall_latency got=%0d exp=6", rc - g); else passed++;
        checks++; if (bad != 0) $display("FAIL stall_payload got=%0d exp=0", bad); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int g, r;
        bit gto, rto;
        r_hold = 1'b1;
        issue(1'b0, 1'b0, 4'h0, 32'h0, g, gto);
        step();
        checks++; if (gto || axi.rready !== 1'b1 || busy !== 1'b1)
            $display("FAIL rst_pre_rready got=%b/%b exp=1/1", axi.rready, busy); else passed++;
        rst_n = 1'b0;
        step();
        checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0)
            $display("FAIL rst_axi got=%b/%b exp=0/0", axi.arvalid, axi.rready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp got=%b exp=00", rsp_valid); else passed++;
        step();
        checks++; if (rsp_valid !== 2'b00 || grant_idx !== 1'b0)
            $display("FAIL rst_hold got=%b/%0d exp=00/0", rsp_valid, grant_idx); else passed++;
        r_hold = 1'b0;
        rst_n = 1'b1;
        issue(1'b1, 1'b0, 4'h4, 32'h0, g, gto);
        wait_rsp(1'b1, r, rto);
        checks++; if (gto || rto || r - g != 3)
            $display("FAIL rst_req1_latency got=%0d exp=3", r - g); else passed++;
        checks++; if (rsp_rdata !== 32'h2 || grant_idx !== 1'b1)
            $display("FAIL rst_req1_data got=%h/%0d exp=2/1", rsp_rdata, grant_idx); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int  g1, rc, r0, early;
        bit  gto, seen, rto;
        seen = 1'b0; rc = 0; early = 0;
        issue(1'b1, 1'b0, 4'h8, 32'h0, g1, gto);
        req_we[0] = 1'b1; r_addr[0] = 4'h0; r_wdata[0] = 32'h77; r_wstrb[0] = 4'hF;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin seen = 1'b1; rc = cyc; break; end
            if (req_ready != 2'b00) early++;
        end
        checks++; if (gto || !seen || rc - g1 != 3)
            $display("FAIL b2b_req1_latency got=%0d exp=3", rc - g1); else passed++;
        checks++; if (req_ready !== 2'b01)
            $display("FAIL b2b_same_cycle_grant got=%b exp=01", req_ready); else passed++;
        checks++; if (rsp_rdata !== 32'h33)
            $display("FAIL b2b_req1_rdata got=%h exp=33", rsp_rdata); else passed++;
        checks++; if (early != 0)
            $display("FAIL b2b_busy_grant got=%0d exp=0", early); else passed++;
        step();
        req_valid[0] = 1'b0;
        wait_rsp(1'b0, r0, rto);
        checks++; if (rto || r0 - rc != 3 || rsp_rdata !== 32'h0)
            $display("FAIL b2b_req0 got=%0d/%h exp=3/0", r0 - rc, rsp_rdata); else passed++;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0;
        end
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
        test_arbitration();
        test_write_read();
        test_slverr();
        test_aw_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
